siso_frame_reader: RTL and testbench

Drains length-prefixed byte frames from a `siso` byte FIFO and emits them as an 8-bit AXI-Stream with `tlast`. Sits on the read side of the FIFO, between the FIFO and the Ethernet TX path. It parses a 2-byte big-endian length header per frame, forwards that many payload bytes through a one-entry output register, and discards frames with illegal lengths while keeping byte alignment.

---
 rtl/siso_frame_pkg.sv | 6 +
 rtl/siso_frame_reader.sv | 85 ++++++++
 tb/tb_siso_frame_reader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/siso_frame_pkg.sv
// siso_frame_pkg: shared types and constants for the length-prefixed frame reader
package siso_frame_pkg;
  localparam int LEN_WIDTH = 16;
  localparam int MAX_LEN_DEFAULT = 1518;
  typedef enum logic [1:0] {LEN_HI, LEN_LO, PAYLOAD, DROP} state_t;
endpackage

// File: rtl/siso_frame_reader.sv
// siso_frame_reader: drains length-prefixed frames from a FWFT byte FIFO onto an 8-bit AXI-Stream
module siso_frame_reader
  import siso_frame_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_done,
  output logic       len_err,
  output logic       busy
);
  state_t state, state_nxt;
  logic [7:0] len_hi;
  logic [LEN_WIDTH-1:0] cnt, cnt_nxt, len;
  logic pop, hs, bad_len;
  assign len = {len_hi, fifo_dout};
  assign hs = m_axis_tvalid & m_axis_tready;
  assign bad_len = (len == '0) | (len > LEN_WIDTH'(MAX_LEN));
  assign fifo_rd_en = pop & ~rst;
  assign busy = (state != LEN_HI) | m_axis_tvalid;
  // next state, pop decision and remaining-byte count; payload pops only when the output slot frees up
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    pop = 1'b0;
    case (state)
      LEN_HI: begin
        pop = ~fifo_empty;
        if (pop) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        pop = ~fifo_empty;
        if (pop) begin
          cnt_nxt = len;
          state_nxt = (len == '0) ? LEN_HI : (len > LEN_WIDTH'(MAX_LEN)) ? DROP : PAYLOAD;
        end
      end
      PAYLOAD, DROP: begin
        pop = ~fifo_empty & ((state == DROP) | ~m_axis_tvalid | m_axis_tready);
        if (pop && cnt != '0) cnt_nxt = cnt - 1'b1;
        if (pop && cnt <= LEN_WIDTH'(1)) state_nxt = LEN_HI;
      end
      default: state_nxt = LEN_HI;
    endcase
  end
  // control registers: state, counter, header high byte and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LEN_HI;
      cnt <= '0;
      len_hi <= '0;
      frame_done <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (state == LEN_HI && pop) len_hi <= fifo_dout;
      frame_done <= hs & m_axis_tlast;
      len_err <= (state == LEN_LO) & pop & bad_len;
    end
  end
  // one-entry output register: a pop reloads it, a handshake without a pop empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
    end else if (state == PAYLOAD && pop) begin
      m_axis_tdata <= fifo_dout;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast <= (cnt == LEN_WIDTH'(1));
    end else if (hs) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
    end
  end
endmodule

// File: tb/tb_siso_frame_reader.sv
// tb_siso_frame_reader: directed checks of the frame reader against a FWFT FIFO model
module tb_siso_frame_reader;
  logic clk = 1'b0;
  logic rst;
  logic fifo_rd_en, fifo_empty;
  logic [7:0] fifo_dout;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, frame_done, len_err, busy;
  logic flush;
  logic [7:0] mem [0:2047];
  logic [10:0] wp = '0;
  logic [10:0] rp = '0;
  logic [7:0] got [0:63];
  int ng = 0;
  int checks = 0;
  int errors = 0;
  int base;
  int bad;
  logic [7:0] exp5 [0:5] = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2};

  siso_frame_reader dut (
    .clk(clk),
    .rst(rst),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .frame_done(frame_done),
    .len_err(len_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rp == wp);
  assign fifo_dout = mem[rp];

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (fifo_rd_en && !fifo_empty) rp <= rp + 11'd1;
  end

  always @(posedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      got[ng % 64] <= m_axis_tdata;
      ng <= ng + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 11'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    m_axis_tready = 1'b1;
    flush = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    push(8'h00); push(8'h03); push(8'hAA); push(8'hBB); push(8'hCC);
    step();
    step();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 8'h00);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1 chk("rel_rd_en", fifo_rd_en, 1);
    step();
    chk("s1_busy", busy, 1);
    chk("s1_tvalid", m_axis_tvalid, 0);
    step();
    step();
    chk("s1_b0", m_axis_tdata, 8'hAA);
    chk("s1_v0", m_axis_tvalid, 1);
    chk("s1_l0", m_axis_tlast, 0);
    step();
    chk("s1_b1", m_axis_tdata, 8'hBB);
    chk("s1_l1", m_axis_tlast, 0);
    step();
    chk("s1_b2", m_axis_tdata, 8'hCC);
    chk("s1_l2", m_axis_tlast, 1);
    step();
    chk("s1_drain", m_axis_tvalid, 0);
    chk("s1_done", frame_done, 1);
    chk("s1_idle", busy, 0);
    step();
    chk("s1_done_pulse", frame_done, 0);

    base = ng;
    push(8'h00); push(8'h08);
    for (int i = 1; i <= 8; i++) push(8'(i));
    step(); step(); step(); step(); step();
    chk("bp_b3", m_axis_tdata, 8'h03);
    m_axis_tready = 1'b0;
    #1 chk("bp_rd_en0", fifo_rd_en, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_data", m_axis_tdata, 8'h03);
      chk("bp_hold_valid", m_axis_tvalid, 1);
      chk("bp_hold_rd_en", fifo_rd_en, 0);
    end
    m_axis_tready = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      step();
      chk("bp_beat", m_axis_tdata, 8'(k));
      chk("bp_last", m_axis_tlast, (k == 8) ? 1 : 0);
    end
    step();
    chk("bp_drain", m_axis_tvalid, 0);
    chk("bp_count", ng - base, 8);
    for (int k = 0; k < 8; k++) chk("bp_order", got[(base + k) % 64], 8'(k + 1));

    push(8'h00); push(8'h04); push(8'h11); push(8'h22);
    step(); step(); step();
    chk("uf_b0", m_axis_tdata, 8'h11);
    step();
    chk("uf_b1", m_axis_tdata, 8'h22);
    step();
    chk("uf_gap_valid", m_axis_tvalid, 0);
    chk("uf_gap_busy", busy, 1);
    step(); step();
    chk("uf_gap_rd_en", fifo_rd_en, 0);
    chk("uf_gap_valid2", m_axis_tvalid, 0);
    push(8'h33); push(8'h44);
    #1 chk("uf_resume_rd_en", fifo_rd_en, 1);
    step();
    chk("uf_b2", m_axis_tdata, 8'h33);
    chk("uf_l2", m_axis_tlast, 0);
    step();
    chk("uf_b3", m_axis_tdata, 8'h44);
    chk("uf_l3", m_axis_tlast, 1);
    step();
    chk("uf_done", frame_done, 1);

    push(8'h00); push(8'h00);
    step(); step();
    chk("zero_len_err", len_err, 1);
    chk("zero_tvalid", m_axis_tvalid, 0);
    push(8'h05); push(8'hEF);
    for (int i = 0; i < 1519; i++) push(8'(i));
    push(8'h00); push(8'h01); push(8'h5A);
    step();
    chk("len_err_pulse", len_err, 0);
    step();
    chk("big_len_err", len_err, 1);
    bad = 0;
    for (int i = 0; i < 1519; i++) begin
      step();
      if (m_axis_tvalid) bad++;
    end
    chk("drop_quiet", bad, 0);
    chk("drop_end_busy", busy, 0);
    step(); step(); step();
    chk("after_drop_b", m_axis_tdata, 8'h5A);
    chk("after_drop_l", m_axis_tlast, 1);
    chk("after_drop_v", m_axis_tvalid, 1);
    step();
    chk("after_drop_done", frame_done, 1);

    base = ng;
    for (int f = 0; f < 3; f++) begin
      push(8'h00); push(8'h02); push(exp5[2*f]); push(exp5[2*f+1]);
    end
    step(); step(); step(); step(); step();
    chk("b2b_done_f1", frame_done, 1);
    for (int i = 0; i < 8; i++) step();
    chk("b2b_count", ng - base, 6);
    for (int k = 0; k < 6; k++) chk("b2b_order", got[(base + k) % 64], exp5[k]);

    push(8'h00); push(8'h02); push(8'hD1); push(8'hD2);
    push(8'h00); push(8'h02); push(8'hE1); push(8'hE2);
    for (int i = 0; i < 7; i++) step();
    chk("mid_b", m_axis_tdata, 8'hE1);
    rst = 1'b1;
    flush = 1'b1;
    #1;
    chk("async_tvalid", m_axis_tvalid, 0);
    chk("async_tdata", m_axis_tdata, 8'h00);
    chk("async_tlast", m_axis_tlast, 0);
    chk("async_rd_en", fifo_rd_en, 0);
    chk("async_busy", busy, 0);
    step();
    rst = 1'b0;
    flush = 1'b0;
    #1 chk("post_rst_rd_en", fifo_rd_en, 0);
    step();
    chk("post_rst_tvalid", m_axis_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
